// File: rtl/meta_window_sweep.sv
// Sweep controller for the metastability detector: steps win_sel over a
// range, settles, counts detector errors per window and tracks the minimum.
module meta_window_sweep #(
  parameter int WIN_W         = 4,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int MEAS_CYCLES   = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_lo,
  input  logic [WIN_W-1:0] win_hi,
  input  logic             error,
  output logic [WIN_W-1:0] win_sel,
  output logic             busy,
  output logic             res_valid,
  output logic [WIN_W-1:0] res_win,
  output logic [CNT_W-1:0] res_cnt,
  output logic [WIN_W-1:0] best_win,
  output logic [CNT_W-1:0] best_cnt,
  output logic             done,
  output logic             cfg_err
);

  localparam int TMAX = (SETTLE_CYCLES > MEAS_CYCLES) ?
                        SETTLE_CYCLES : MEAS_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] S_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] M_LD = TW'(MEAS_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, MEASURE, REPORT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] hi_q, hi_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [WIN_W-1:0] win_sel_q, win_sel_d;
  logic [WIN_W-1:0] res_win_q, res_win_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [WIN_W-1:0] best_win_q, best_win_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    tmr_d      = tmr_q;
    cnt_d      = cnt_q;
    win_sel_d  = win_sel_q;
    res_win_d  = res_win_q;
    res_cnt_d  = res_cnt_q;
    best_win_d = best_win_q;
    best_cnt_d = best_cnt_q;
    cfg_err_d  = 1'b0;
    cnt_inc    = (error && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    // abort wins over every transition and freezes results
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (win_lo <= win_hi) begin
              hi_d       = win_hi;
              win_sel_d  = win_lo;
              best_cnt_d = '1;
              cnt_d      = '0;
              tmr_d      = S_LD;
              state_d    = SETTLE;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        SETTLE: begin
          if (tmr_q == '0) begin
            tmr_d   = M_LD;
            cnt_d   = '0;
            state_d = MEASURE;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        MEASURE: begin
          cnt_d = cnt_inc;
          if (tmr_q == '0) begin
            state_d   = REPORT;
            res_win_d = win_sel_q;
            res_cnt_d = cnt_inc;
            if (cnt_inc < best_cnt_q) begin
              best_win_d = win_sel_q;
              best_cnt_d = cnt_inc;
            end
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        REPORT: begin
          // compare before increment so the top window never wraps
          if (win_sel_q == hi_q) begin
            state_d = DONE;
          end else begin
            win_sel_d = win_sel_q + 1'b1;
            tmr_d     = S_LD;
            state_d   = SETTLE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d      = (state_d != IDLE);
    res_valid_d = (state_d == REPORT);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      tmr_q       <= '0;
      cnt_q       <= '0;
      win_sel_q   <= '0;
      res_win_q   <= '0;
      res_cnt_q   <= '0;
      best_win_q  <= '0;
      best_cnt_q  <= '1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      win_sel_q   <= win_sel_d;
      res_win_q   <= res_win_d;
      res_cnt_q   <= res_cnt_d;
      best_win_q  <= best_win_d;
      best_cnt_q  <= best_cnt_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign win_sel   = win_sel_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_win   = res_win_q;
  assign res_cnt   = res_cnt_q;
  assign best_win  = best_win_q;
  assign best_cnt  = best_cnt_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_meta_window_sweep.sv
// Bench for meta_window_sweep: window-arithmetic model plus
// directed sweeps on a default and an 8-bit-counter instance.
module tb_meta_window_sweep;

  localparam int S = 4;
  localparam int M = 1024;
  localparam int P = S + M + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic error = 1'b0;
  logic [3:0] win_lo = '0;
  logic [3:0] win_hi = '0;

  logic [3:0]  a_win_sel, a_res_win, a_best_win;
  logic [15:0] a_res_cnt, a_best_cnt;
  logic        a_busy, a_rv, a_done, a_cfg;
  logic [3:0]  b_win_sel, b_res_win, b_best_win;
  logic [7:0]  b_res_cnt, b_best_cnt;
  logic        b_busy, b_rv, b_done, b_cfg;

  always #5 clk = ~clk;

  meta_window_sweep u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .abort(abort), .win_lo(win_lo), .win_hi(win_hi),
    .error(error), .win_sel(a_win_sel), .busy(a_busy),
    .res_valid(a_rv), .res_win(a_res_win),
    .res_cnt(a_res_cnt), .best_win(a_best_win),
    .best_cnt(a_best_cnt), .done(a_done), .cfg_err(a_cfg)
  );

  meta_window_sweep #(.CNT_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .abort(abort), .win_lo(win_lo), .win_hi(win_hi),
    .error(error), .win_sel(b_win_sel), .busy(b_busy),
    .res_valid(b_rv), .res_win(b_res_win),
    .res_cnt(b_res_cnt), .best_win(b_best_win),
    .best_cnt(b_best_cnt), .done(b_done), .cfg_err(b_cfg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // model: cycle t after the accepting edge, window k=(t-1)/P
  int m_t, m_lo, m_n;
  int m_cnt[16];
  int e_win_sel, e_res_win, e_res_a, e_res_b;
  int e_bw_a, e_bc_a, e_bw_b, e_bc_b;
  bit e_busy, e_rv, e_done, e_cfg;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_t = 0; m_lo = 0; m_n = 0;
    e_win_sel = 0; e_res_win = 0; e_res_a = 0; e_res_b = 0;
    e_bw_a = 0; e_bc_a = 65535; e_bw_b = 0; e_bc_b = 255;
    e_busy = 0; e_rv = 0; e_done = 0; e_cfg = 0;
  endtask

  task automatic model_step();
    int p, k;
    e_rv = 0; e_done = 0; e_cfg = 0;
    if (!rst_n) begin
      model_reset();
    end else if (m_t > 0) begin
      if (abort) begin
        m_t = 0; e_busy = 0;
      end else begin
        p = (m_t - 1) % P; k = (m_t - 1) / P;
        if (m_t <= m_n * P && p >= S && p < S + M && error)
          m_cnt[k]++;
        m_t++;
        if (m_t == m_n * P + 2) begin
          m_t = 0; e_busy = 0;
        end else if (m_t == m_n * P + 1) begin
          e_done = 1;
        end else begin
          p = (m_t - 1) % P; k = (m_t - 1) / P;
          e_win_sel = m_lo + k;
          if (p == P - 1) begin
            e_rv = 1; e_res_win = m_lo + k;
            e_res_a = sat(m_cnt[k], 65535);
            e_res_b = sat(m_cnt[k], 255);
            if (e_res_a < e_bc_a) begin
              e_bc_a = e_res_a; e_bw_a = m_lo + k;
            end
            if (e_res_b < e_bc_b) begin
              e_bc_b = e_res_b; e_bw_b = m_lo + k;
            end
          end
        end
      end
    end else if (start) begin
      if (win_lo <= win_hi) begin
        m_lo = int'(win_lo); m_n = int'(win_hi) - m_lo + 1;
        m_t = 1; e_busy = 1; e_win_sel = m_lo;
        e_bc_a = 65535; e_bc_b = 255;
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      end else begin
        e_cfg = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_win_sel", 32'(a_win_sel), 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_best_cnt", 32'(a_best_cnt), 65535);
        chk("rst_res_cnt", 32'(a_res_cnt), 0);
      end else begin
        chk("win_sel", 32'(a_win_sel), 32'(e_win_sel));
        chk("busy", 32'(a_busy), 32'(e_busy));
        chk("res_valid", 32'(a_rv), 32'(e_rv));
        chk("done", 32'(a_done), 32'(e_done));
        chk("cfg_err", 32'(a_cfg), 32'(e_cfg));
        chk("s_win_sel", 32'(b_win_sel), 32'(e_win_sel));
        chk("s_busy", 32'(b_busy), 32'(e_busy));
        chk("s_res_valid", 32'(b_rv), 32'(e_rv));
        chk("s_done", 32'(b_done), 32'(e_done));
        if (e_rv) begin
          chk("res_win", 32'(a_res_win), 32'(e_res_win));
          chk("res_cnt", 32'(a_res_cnt), 32'(e_res_a));
          chk("s_res_cnt", 32'(b_res_cnt), 32'(e_res_b));
        end
        if (!e_busy || e_done) begin
          chk("best_win", 32'(a_best_win), 32'(e_bw_a));
          chk("best_cnt", 32'(a_best_cnt), 32'(e_bc_a));
          chk("s_best_win", 32'(b_best_win), 32'(e_bw_b));
          chk("s_best_cnt", 32'(b_best_cnt), 32'(e_bc_b));
        end
      end
    end
  end

  int cyc, n_rv, done_cyc;
  int rv_cyc[8], rv_win[8], rv_cnt[8], rv_cnt8[8];

  // emode 0: quiet, 1: always error, 2: min-search pattern
  // ev_kind 1: abort, 2: second start, 3: reset
  task automatic sweep(input int lo, input int hi, input int emode,
                       input int ev_cyc, input int ev_kind,
                       input int maxc);
    bit fin;
    int p, w;
    win_lo = 4'(lo); win_hi = 4'(hi); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; n_rv = 0; done_cyc = 0; fin = 0;
    while (!fin) begin
      if (a_rv && n_rv < 8) begin
        rv_cyc[n_rv] = cyc; rv_win[n_rv] = int'(a_res_win);
        rv_cnt[n_rv] = int'(a_res_cnt);
        rv_cnt8[n_rv] = int'(b_res_cnt);
        n_rv++;
      end
      if (a_done) done_cyc = cyc;
      if (a_done || cyc >= maxc) fin = 1;
      p = (cyc - 1) % P; w = lo + (cyc - 1) / P;
      case (emode)
        1: error = 1'b1;
        2: error = (p < S) ? cyc[0] : ((p < S + M) ? (w != 6) : 1'b1);
        default: error = 1'b0;
      endcase
      if (!fin && cyc == ev_cyc) begin
        if (ev_kind == 1) abort = 1'b1;
        if (ev_kind == 2) begin
          win_lo = 4'd0; win_hi = 4'd1; start = 1'b1;
        end
        if (ev_kind == 3) begin
          #3 rst_n = 1'b0;
          #1;
          chk("rst_now_win_sel", 32'(a_win_sel), 0);
          chk("rst_now_busy", 32'(a_busy), 0);
          chk("rst_now_best", 32'(a_best_cnt), 65535);
          chk("rst_now_best8", 32'(b_best_cnt), 255);
          fin = 1;
        end
      end
      @(negedge clk);
      cyc++; abort = 1'b0; start = 1'b0;
      if (ev_kind == 1 && cyc == ev_cyc + 1)
        chk("abort_busy", 32'(a_busy), 0);
    end
    error = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("init_win_sel", 32'(a_win_sel), 0);
    chk("init_best_cnt", 32'(a_best_cnt), 65535);
    rst_n = 1'b1;
    @(negedge clk);

    // quiet sweep 2..4 with an ignored second start
    sweep(2, 4, 0, 500, 2, 4000);
    chk("ef_nrv", 32'(n_rv), 3);
    chk("ef_rv0", 32'(rv_cyc[0]), 1029);
    chk("ef_gap", 32'(rv_cyc[1] - rv_cyc[0]), 1029);
    chk("ef_win2", 32'(rv_win[2]), 4);
    chk("ef_cnt1", 32'(rv_cnt[1]), 0);
    chk("ef_done", 32'(done_cyc), 3088);
    chk("ef_best_win", 32'(a_best_win), 2);
    chk("ef_best_cnt", 32'(a_best_cnt), 0);

    // saturation on the 8-bit instance
    sweep(0, 0, 1, 0, 0, 2000);
    chk("sat_cnt8", 32'(rv_cnt8[0]), 255);
    chk("sat_cnt16", 32'(rv_cnt[0]), 1024);
    chk("sat_best8", 32'(b_best_cnt), 255);

    // minimum search with settle toggles
    sweep(3, 7, 2, 0, 0, 6000);
    chk("min_cnt0", 32'(rv_cnt[0]), 1024);
    chk("min_cnt3", 32'(rv_cnt[3]), 0);
    chk("min_cnt4", 32'(rv_cnt[4]), 1024);
    chk("min_best", 32'(a_best_win), 6);

    // top of range
    sweep(15, 15, 0, 0, 0, 2000);
    chk("top_win", 32'(rv_win[0]), 15);
    chk("top_done", 32'(done_cyc), 1030);
    chk("top_sel", 32'(a_win_sel), 15);

    // rejected start
    win_lo = 4'd5; win_hi = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_pulse", 32'(a_cfg), 1);
    chk("cfg_busy", 32'(a_busy), 0);
    @(negedge clk);
    chk("cfg_clear", 32'(a_cfg), 0);

    // abort in MEASURE of window 1
    sweep(2, 4, 0, P + S + 100, 1, 3200);
    chk("abort_nrv", 32'(n_rv), 1);
    chk("abort_done", 32'(done_cyc), 0);
    chk("abort_best", 32'(a_best_win), 2);

    // reset mid-sweep, then a full sweep
    sweep(2, 4, 1, 1500, 3, 4000);
    sweep(2, 4, 0, 0, 0, 4000);
    chk("post_rst_done", 32'(done_cyc), 3088);
    chk("post_rst_nrv", 32'(n_rv), 3);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
